// File: rtl/adxl345_spi_responder_pkg.sv
// Shared register map, reset values and FSM encoding for the ADXL345 SPI responder.
package adxl345_spi_responder_pkg;

  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [5:0] ADDR_DATAX1      = 6'h33;
  localparam logic [5:0] ADDR_DATAY0      = 6'h34;
  localparam logic [5:0] ADDR_DATAY1      = 6'h35;
  localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
  localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

  localparam logic [7:0] BW_RATE_RST     = 8'h0A;
  localparam logic [7:0] POWER_CTL_RST   = 8'h00;
  localparam logic [7:0] DATA_FORMAT_RST = 8'h00;

  typedef enum logic [1:0] {IDLE, CMD, RD, WR} state_t;

endpackage

// File: rtl/adxl345_spi_responder_spi_sync_edge.sv
// Synchronises nCS/SClk/SDI into the system clock and flags SClk rising/falling edges.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ncs,
  input  logic sclk,
  input  logic sdi,
  output logic ncs_s,
  output logic sdi_s,
  output logic sclk_rise,
  output logic sclk_fall
);

  logic [SYNC_STAGES-1:0] ncs_ff;
  logic [SYNC_STAGES-1:0] sclk_ff;
  logic [SYNC_STAGES-1:0] sdi_ff;
  logic                   sclk_d;

  // nCS and SClk reset to their idle-high levels so no spurious edge follows reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncs_ff  <= '1;
      sclk_ff <= '1;
      sdi_ff  <= '0;
      sclk_d  <= 1'b1;
    end else begin
      ncs_ff  <= {ncs_ff[SYNC_STAGES-2:0], ncs};
      sclk_ff <= {sclk_ff[SYNC_STAGES-2:0], sclk};
      sdi_ff  <= {sdi_ff[SYNC_STAGES-2:0], sdi};
      sclk_d  <= sclk_ff[SYNC_STAGES-1];
    end
  end

  assign ncs_s     = ncs_ff[SYNC_STAGES-1];
  assign sdi_s     = sdi_ff[SYNC_STAGES-1];
  assign sclk_rise = sclk_ff[SYNC_STAGES-1] & ~sclk_d;
  assign sclk_fall = ~sclk_ff[SYNC_STAGES-1] & sclk_d;

endmodule

// File: rtl/adxl345_spi_responder.sv
// SPI mode-3 slave emulating the ADXL345 register interface, oversampled in the Clk_100M domain.
module adxl345_spi_responder
  import adxl345_spi_responder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DEVID       = 8'hE5
) (
  input  logic        Clk_100M,
  input  logic        nReset,
  input  logic [15:0] X,
  input  logic [15:0] Y,
  input  logic [15:0] Z,
  input  logic        nCS,
  input  logic        SClk,
  input  logic        SDI,
  output logic        SDO,
  output logic        SDO_En,
  output logic [7:0]  BW_Rate,
  output logic [7:0]  Power_Ctl,
  output logic [7:0]  Data_Format,
  output logic        Write_Strobe,
  output logic [5:0]  Write_Addr
);

  logic ncs_s, sdi_s, sclk_rise, sclk_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (Clk_100M),
    .rst_n     (nReset),
    .ncs       (nCS),
    .sclk      (SClk),
    .sdi       (SDI),
    .ncs_s     (ncs_s),
    .sdi_s     (sdi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_in;
  logic [7:0]  shift_out;
  logic        mb;
  logic [5:0]  addr;
  logic [15:0] x_h, y_h, z_h;

  logic [7:0]  byte_in;
  logic [5:0]  next_addr;

  assign byte_in   = {shift_in[6:0], sdi_s};
  assign next_addr = mb ? addr + 6'd1 : addr;

  function automatic logic [7:0] read_reg(input logic [5:0] a, input logic [15:0] xs,
                                          input logic [15:0] ys, input logic [15:0] zs);
    case (a)
      ADDR_DEVID:       read_reg = DEVID;
      ADDR_BW_RATE:     read_reg = BW_Rate;
      ADDR_POWER_CTL:   read_reg = Power_Ctl;
      ADDR_DATA_FORMAT: read_reg = Data_Format;
      ADDR_DATAX0:      read_reg = xs[7:0];
      ADDR_DATAX1:      read_reg = xs[15:8];
      ADDR_DATAY0:      read_reg = ys[7:0];
      ADDR_DATAY1:      read_reg = ys[15:8];
      ADDR_DATAZ0:      read_reg = zs[7:0];
      ADDR_DATAZ1:      read_reg = zs[15:8];
      default:          read_reg = 8'h00;
    endcase
  endfunction

  always_ff @(posedge Clk_100M or negedge nReset) begin
    if (!nReset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift_in     <= '0;
      shift_out    <= '0;
      mb           <= 1'b0;
      addr         <= '0;
      x_h          <= '0;
      y_h          <= '0;
      z_h          <= '0;
      SDO          <= 1'b0;
      SDO_En       <= 1'b0;
      BW_Rate      <= BW_RATE_RST;
      Power_Ctl    <= POWER_CTL_RST;
      Data_Format  <= DATA_FORMAT_RST;
      Write_Strobe <= 1'b0;
      Write_Addr   <= '0;
    end else begin
      Write_Strobe <= 1'b0;
      SDO_En       <= ~ncs_s;
      // nCS high overrides any coincident SClk edge, dropping partial bytes
      if (ncs_s) begin
        state   <= IDLE;
        bit_cnt <= '0;
        SDO     <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= CMD;
          CMD: begin
            SDO <= 1'b0;
            if (sclk_rise) begin
              shift_in <= byte_in;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                mb   <= byte_in[6];
                addr <= byte_in[5:0];
                x_h  <= X;
                y_h  <= Y;
                z_h  <= Z;
                if (byte_in[7]) begin
                  // live inputs equal the snapshot being captured this cycle
                  shift_out <= read_reg(byte_in[5:0], X, Y, Z);
                  state     <= RD;
                end else begin
                  state <= WR;
                end
              end
            end
          end
          RD: begin
            if (sclk_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                addr      <= next_addr;
                shift_out <= read_reg(next_addr, x_h, y_h, z_h);
              end
            end else if (sclk_fall) begin
              SDO       <= shift_out[7];
              shift_out <= {shift_out[6:0], 1'b0};
            end
          end
          WR: begin
            if (sclk_rise) begin
              shift_in <= byte_in;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                addr <= next_addr;
                case (addr)
                  ADDR_BW_RATE: begin
                    BW_Rate      <= byte_in;
                    Write_Strobe <= 1'b1;
                    Write_Addr   <= addr;
                  end
                  ADDR_POWER_CTL: begin
                    Power_Ctl    <= byte_in;
                    Write_Strobe <= 1'b1;
                    Write_Addr   <= addr;
                  end
                  ADDR_DATA_FORMAT: begin
                    Data_Format  <= byte_in;
                    Write_Strobe <= 1'b1;
                    Write_Addr   <= addr;
                  end
                  default: ;
                endcase
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adxl345_spi_responder.sv
// Scoreboard bench: an SPI mode-3 master drives the responder; monitors check read bytes and write strobes.
module tb_adxl345_spi_responder;

  logic        Clk_100M = 1'b0;
  logic        nReset;
  logic [15:0] X, Y, Z;
  logic        nCS, SClk, SDI;
  logic        SDO, SDO_En;
  logic [7:0]  BW_Rate, Power_Ctl, Data_Format;
  logic        Write_Strobe;
  logic [5:0]  Write_Addr;

  adxl345_spi_responder #(.SYNC_STAGES(2), .DEVID(8'hE5)) dut (
    .Clk_100M     (Clk_100M),
    .nReset       (nReset),
    .X            (X),
    .Y            (Y),
    .Z            (Z),
    .nCS          (nCS),
    .SClk         (SClk),
    .SDI          (SDI),
    .SDO          (SDO),
    .SDO_En       (SDO_En),
    .BW_Rate      (BW_Rate),
    .Power_Ctl    (Power_Ctl),
    .Data_Format  (Data_Format),
    .Write_Strobe (Write_Strobe),
    .Write_Addr   (Write_Addr)
  );

  always #5 Clk_100M = ~Clk_100M;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [7:0]  exp_rd[$];
  logic [5:0]  exp_wr[$];
  logic [7:0]  rx_byte;
  event        rx_ev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // read-byte monitor
  initial begin
    forever begin
      @(rx_ev);
      if (exp_rd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got %0h expected none", rx_byte);
      end else begin
        check("rx_byte", {24'h0, rx_byte}, {24'h0, exp_rd.pop_front()});
      end
    end
  end

  // write-strobe monitor
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge Clk_100M);
      if (Write_Strobe) begin
        if (prev) begin
          checks++;
          errors++;
          $display("FAIL strobe_width: got 2+ cycles expected 1");
        end else if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL strobe_unexpected: got addr %0h expected no strobe", Write_Addr);
        end else begin
          check("write_addr", {26'h0, Write_Addr}, {26'h0, exp_wr.pop_front()});
        end
      end
      prev = Write_Strobe;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // master shifts on SClk low, samples SDO just before the rising edge
  task automatic spi_bits(input logic [7:0] tx, input int unsigned n, output logic [7:0] rx);
    rx = '0;
    for (int unsigned i = 0; i < n; i++) begin
      SClk = 1'b0;
      SDI  = tx[7-i];
      #80;
      rx   = {rx[6:0], SDO};
      SClk = 1'b1;
      #80;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, input bit chk, input logic [7:0] exp);
    logic [7:0] rx;
    if (chk) exp_rd.push_back(exp);
    spi_bits(tx, 8, rx);
    if (chk) begin
      rx_byte = rx;
      ->rx_ev;
    end
  endtask

  task automatic cs_start();
    nCS = 1'b0;
    #100;
  endtask

  task automatic cs_end();
    #100;
    nCS = 1'b1;
    #200;
  endtask

  initial begin
    logic [7:0] rx;
    nReset = 1'b0;
    nCS = 1'b1; SClk = 1'b1; SDI = 1'b0;
    X = 16'h0; Y = 16'h0; Z = 16'h0;
    #22;
    check("rst_sdo", {31'h0, SDO}, 32'h0);
    check("rst_sdo_en", {31'h0, SDO_En}, 32'h0);
    check("rst_bw_rate", {24'h0, BW_Rate}, 32'h0A);
    check("rst_power_ctl", {24'h0, Power_Ctl}, 32'h00);
    check("rst_data_format", {24'h0, Data_Format}, 32'h00);
    check("rst_write_strobe", {31'h0, Write_Strobe}, 32'h0);
    check("rst_write_addr", {26'h0, Write_Addr}, 32'h0);
    nReset = 1'b1;
    #100;

    // single DEVID read; command-phase SDO must read back as 0
    cs_start();
    check("sdo_en_active", {31'h0, SDO_En}, 32'h1);
    xfer(8'h80, 1'b1, 8'h00);
    xfer(8'h00, 1'b1, 8'hE5);
    cs_end();
    check("sdo_en_idle", {31'h0, SDO_En}, 32'h0);

    // burst sample read, X changes mid-burst
    X = 16'h1234; Y = 16'hFF80; Z = 16'h0001;
    cs_start();
    xfer(8'hF2, 1'b1, 8'h00);
    xfer(8'h00, 1'b1, 8'h34);
    xfer(8'h00, 1'b1, 8'h12);
    X = 16'hAAAA;
    xfer(8'h00, 1'b1, 8'h80);
    xfer(8'h00, 1'b1, 8'hFF);
    xfer(8'h00, 1'b1, 8'h01);
    xfer(8'h00, 1'b1, 8'h00);
    cs_end();

    // single write to Power_Ctl, then read back
    exp_wr.push_back(6'h2D);
    cs_start();
    xfer(8'h2D, 1'b0, 8'h00);
    xfer(8'h08, 1'b0, 8'h00);
    cs_end();
    check("power_ctl_w", {24'h0, Power_Ctl}, 32'h08);
    cs_start();
    xfer(8'hAD, 1'b1, 8'h00);
    xfer(8'h00, 1'b1, 8'h08);
    cs_end();

    // burst write from 0x2C
    exp_wr.push_back(6'h2C);
    exp_wr.push_back(6'h2D);
    cs_start();
    xfer(8'h6C, 1'b0, 8'h00);
    xfer(8'h0F, 1'b0, 8'h00);
    xfer(8'h18, 1'b0, 8'h00);
    cs_end();
    check("bw_rate_burst", {24'h0, BW_Rate}, 32'h0F);
    check("power_ctl_burst", {24'h0, Power_Ctl}, 32'h18);

    // unmapped write: no strobe, reads 0
    cs_start();
    xfer(8'h10, 1'b0, 8'h00);
    xfer(8'h55, 1'b0, 8'h00);
    cs_end();
    cs_start();
    xfer(8'h90, 1'b1, 8'h00);
    xfer(8'h00, 1'b1, 8'h00);
    cs_end();

    // address wrap 0x3F -> 0x00
    cs_start();
    xfer(8'hFF, 1'b1, 8'h00);
    xfer(8'h00, 1'b1, 8'h00);
    xfer(8'h00, 1'b1, 8'hE5);
    cs_end();

    // aborted write after 4 data bits
    cs_start();
    xfer(8'h31, 1'b0, 8'h00);
    spi_bits(8'hFF, 4, rx);
    cs_end();
    check("data_format_abort", {24'h0, Data_Format}, 32'h00);

    // reset in the middle of a DEVID read
    cs_start();
    xfer(8'h80, 1'b1, 8'h00);
    spi_bits(8'h00, 3, rx);
    check("partial_rx", {24'h0, rx}, 32'h07);
    check("sdo_before_reset", {31'h0, SDO}, 32'h1);
    nReset = 1'b0;
    #1;
    check("mid_rst_sdo", {31'h0, SDO}, 32'h0);
    check("mid_rst_sdo_en", {31'h0, SDO_En}, 32'h0);
    check("mid_rst_bw_rate", {24'h0, BW_Rate}, 32'h0A);
    check("mid_rst_power_ctl", {24'h0, Power_Ctl}, 32'h00);
    nCS = 1'b1;
    #29;
    nReset = 1'b1;
    #200;
    cs_start();
    xfer(8'h80, 1'b1, 8'h00);
    xfer(8'h00, 1'b1, 8'hE5);
    cs_end();
    cs_start();
    xfer(8'hAC, 1'b1, 8'h00);
    xfer(8'h00, 1'b1, 8'h0A);
    cs_end();

    #100;
    check("rd_queue_empty", exp_rd.size(), 32'h0);
    check("wr_queue_empty", exp_wr.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
